// File: rtl/fim_expediente_ctrl.sv
// End-of-shift siren controller: debounces the alarm condition, beeps the siren, and times out or acknowledges.
// Optional snooze on acknowledge is built only when FIM_EXPEDIENTE_SNOOZE_EN is defined.
module fim_expediente_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BEEP_HALF       = 2,
   parameter int SOUND_TIMEOUT   = 20,
   parameter int SNOOZE_CYCLES   = 8
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       noite,
   input  logic       paradas,
   input  logic       sexta,
   input  logic       producao,
   input  logic       ack,
   output logic       sirene,
   output logic [2:0] estado,
   output logic       ativo
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int BW = $clog2(BEEP_HALF) + 1;
   localparam int TW = $clog2(SOUND_TIMEOUT) + 1;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(SOUND_TIMEOUT - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_chk_deb
      $error("DEBOUNCE_CYCLES out of range");
   end
   if (BEEP_HALF < 1 || BEEP_HALF > 255) begin : g_chk_beep
      $error("BEEP_HALF out of range");
   end
   if (SOUND_TIMEOUT < 1 || SOUND_TIMEOUT > 65535) begin : g_chk_tmo
      $error("SOUND_TIMEOUT out of range");
   end
   if (SNOOZE_CYCLES < 1 || SNOOZE_CYCLES > 65535) begin : g_chk_snz
      $error("SNOOZE_CYCLES out of range");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      SOUNDING = 3'd2,
      SILENCED = 3'd3,
      SNOOZE   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic [BW-1:0] beep_cnt, beep_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic          sir_nxt;
   logic          cond;

`ifdef FIM_EXPEDIENTE_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_CYCLES) + 1;
   localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_CYCLES - 1);
   logic [SW-1:0] snz_cnt, snz_nxt;
`endif

   assign cond   = (noite & paradas) | (sexta & producao & paradas);
   assign estado = state;
   assign ativo  = (state == SOUNDING);

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state    <= IDLE;
         deb_cnt  <= '0;
         beep_cnt <= '0;
         tmo_cnt  <= '0;
         sirene   <= 1'b0;
`ifdef FIM_EXPEDIENTE_SNOOZE_EN
         snz_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         deb_cnt  <= deb_nxt;
         beep_cnt <= beep_nxt;
         tmo_cnt  <= tmo_nxt;
         sirene   <= sir_nxt;
`ifdef FIM_EXPEDIENTE_SNOOZE_EN
         snz_cnt  <= snz_nxt;
`endif
      end
   end

   // Counters default to zero so every state entry starts them cleared; sirene is only kept high while staying in SOUNDING.
   always_comb begin
      state_nxt = IDLE;
      deb_nxt   = '0;
      beep_nxt  = '0;
      tmo_nxt   = '0;
      sir_nxt   = 1'b0;
`ifdef FIM_EXPEDIENTE_SNOOZE_EN
      snz_nxt   = '0;
`endif
      case (state)
         IDLE: begin
            if (cond) state_nxt = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!cond) begin
               state_nxt = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = SOUNDING;
               sir_nxt   = 1'b1;
            end else begin
               state_nxt = DEBOUNCE;
               deb_nxt   = (deb_cnt == '1) ? deb_cnt : deb_cnt + 1'b1;
            end
         end
         SOUNDING: begin
            if (!cond) begin
               state_nxt = IDLE;
            end else if (ack) begin
`ifdef FIM_EXPEDIENTE_SNOOZE_EN
               state_nxt = SNOOZE;
`else
               state_nxt = SILENCED;
`endif
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = SILENCED;
            end else begin
               state_nxt = SOUNDING;
               tmo_nxt   = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
               if (beep_cnt == BEEP_LAST) begin
                  sir_nxt = ~sirene;
               end else begin
                  beep_nxt = (beep_cnt == '1) ? beep_cnt : beep_cnt + 1'b1;
                  sir_nxt  = sirene;
               end
            end
         end
         SILENCED: begin
            state_nxt = cond ? SILENCED : IDLE;
         end
`ifdef FIM_EXPEDIENTE_SNOOZE_EN
         SNOOZE: begin
            if (!cond) begin
               state_nxt = IDLE;
            end else if (snz_cnt == SNZ_LAST) begin
               state_nxt = SOUNDING;
               sir_nxt   = 1'b1;
            end else begin
               state_nxt = SNOOZE;
               snz_nxt   = (snz_cnt == '1) ? snz_cnt : snz_cnt + 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fim_expediente_ctrl.sv
// Directed bench for fim_expediente_ctrl in its default build (snooze disabled), default parameters.
module tb_fim_expediente_ctrl;

   logic       clk_2 = 1'b0;
   logic       reset, noite, paradas, sexta, producao, ack;
   logic       sirene, ativo;
   logic [2:0] estado;
   int         total  = 0;
   int         passed = 0;

   fim_expediente_ctrl dut (
      .clk_2    (clk_2),
      .reset    (reset),
      .noite    (noite),
      .paradas  (paradas),
      .sexta    (sexta),
      .producao (producao),
      .ack      (ack),
      .sirene   (sirene),
      .estado   (estado),
      .ativo    (ativo)
   );

   always #5 clk_2 = ~clk_2;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_2);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic sir);
      chk({tag, ".estado"}, 32'(estado), 32'(st));
      chk({tag, ".sirene"}, 32'(sirene), 32'(sir));
      chk({tag, ".ativo"},  32'(ativo),  32'(st == 3'd2));
   endtask

   initial begin
      reset = 1'b1; noite = 1'b0; paradas = 1'b0; sexta = 1'b0; producao = 1'b0; ack = 1'b0;
      tick(2);
      chk_all("reset", 3'd0, 1'b0);

      // Basic path: noite & paradas
      reset = 1'b0; noite = 1'b1; paradas = 1'b1;
      tick(1);
      chk_all("basic_c1", 3'd1, 1'b0);
      tick(3);
      chk_all("basic_c4", 3'd1, 1'b0);
      tick(1);
      chk_all("basic_c5", 3'd2, 1'b1);
      tick(1);
      chk_all("basic_c6", 3'd2, 1'b1);
      tick(1);
      chk_all("basic_c7", 3'd2, 1'b0);
      tick(1);
      chk_all("basic_c8", 3'd2, 1'b0);
      tick(1);
      chk_all("basic_c9", 3'd2, 1'b1);

      // Timeout: 20 SOUNDING cycles (5..24), SILENCED at cycle 25
      tick(15);
      chk_all("tmo_c24", 3'd2, 1'b0);
      tick(1);
      chk_all("tmo_c25", 3'd3, 1'b0);
      ack = 1'b1;
      tick(1);
      chk_all("silenced_ack", 3'd3, 1'b0);
      ack = 1'b0; paradas = 1'b0;
      tick(1);
      chk_all("silenced_drop", 3'd0, 1'b0);

      // Glitch: 3 cycles of cond, then drop
      paradas = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk_all("glitch_deb", 3'd1, 1'b0);
      end
      paradas = 1'b0;
      tick(1);
      chk_all("glitch_idle", 3'd0, 1'b0);

      // Friday path, then ack together with cond drop
      noite = 1'b0; sexta = 1'b1; producao = 1'b1; paradas = 1'b1;
      tick(4);
      chk_all("fri_c4", 3'd1, 1'b0);
      tick(1);
      chk_all("fri_c5", 3'd2, 1'b1);
      ack = 1'b1; paradas = 1'b0;
      tick(1);
      chk_all("ack_vs_cond", 3'd0, 1'b0);
      ack = 1'b0;

      // Friday without production target: no alarm
      paradas = 1'b1; producao = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk_all("fri_noprod", 3'd0, 1'b0);
      end

      // Ack alone goes to SILENCED
      producao = 1'b1;
      tick(5);
      chk_all("ack_pre", 3'd2, 1'b1);
      ack = 1'b1;
      tick(1);
      chk_all("ack_silenced", 3'd3, 1'b0);
      ack = 1'b0;
      tick(2);
      chk_all("ack_hold", 3'd3, 1'b0);
      paradas = 1'b0;
      tick(1);
      chk_all("ack_exit", 3'd0, 1'b0);

      // Reset mid-SOUNDING, then debounce again from a cleared counter
      paradas = 1'b1;
      tick(6);
      chk_all("rst_pre", 3'd2, 1'b1);
      reset = 1'b1;
      tick(1);
      chk_all("rst_mid", 3'd0, 1'b0);
      reset = 1'b0;
      tick(1);
      chk_all("rst_rel", 3'd1, 1'b0);
      tick(3);
      chk_all("rst_deb4", 3'd1, 1'b0);
      tick(1);
      chk_all("rst_snd", 3'd2, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
